// File: rtl/dma_done_tracker.sv
// Per-slot DMA beat accumulator: drains the DMA-done FIFO and issues one completion per slot.
// Optional build macro DMA_DONE_TRACKER_STATS_EN adds saturating pop/completion counters.
module dma_done_tracker #(
    parameter int unsigned P_SLOT_TAG_WIDTH  = 10,
    parameter int unsigned P_FIFO_DATA_WIDTH = P_SLOT_TAG_WIDTH + 15,
    parameter int unsigned P_CNT_WIDTH       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          fifo_rd_en,
    input  logic [P_FIFO_DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                          fifo_empty_n,
    input  logic                          set_en,
    input  logic [P_SLOT_TAG_WIDTH-1:0]   set_tag,
    input  logic [P_CNT_WIDTH-1:0]        set_total,
    output logic                          set_rdy,
    output logic                          cpl_valid,
    output logic [P_SLOT_TAG_WIDTH-1:0]   cpl_tag,
    output logic                          cpl_dir,
    input  logic                          cpl_ready,
    output logic                          err_overrun,
    output logic                          err_unarmed,
    output logic                          busy
`ifdef DMA_DONE_TRACKER_STATS_EN
    ,
    output logic [31:0]                   stat_pop_cnt,
    output logic [31:0]                   stat_cpl_cnt
`endif
);

    localparam int unsigned L_DEPTH  = 1 << P_SLOT_TAG_WIDTH;
    localparam int unsigned L_WORD_W = 1 + 2 * P_CNT_WIDTH;
    localparam int unsigned L_SUM_W  = P_CNT_WIDTH + 1;
    localparam int unsigned L_BEAT_W = 14;

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_CPL    = 3'd4;

    logic [2:0]                  r_state;
    logic [2:0]                  w_state_nxt;
    logic [P_SLOT_TAG_WIDTH-1:0] r_init_addr;
    logic [P_SLOT_TAG_WIDTH-1:0] r_ent_tag;
    logic                        r_ent_dir;
    logic [L_BEAT_W-1:0]         r_ent_cnt;

    logic [L_WORD_W-1:0]         r_mem [0:L_DEPTH-1];
    logic [L_WORD_W-1:0]         r_rd_word;

    logic                        w_we;
    logic [P_SLOT_TAG_WIDTH-1:0] w_waddr;
    logic [L_WORD_W-1:0]         w_wdata;
    logic [P_SLOT_TAG_WIDTH-1:0] w_rd_addr;
    logic                        w_ld_entry;
    logic                        w_ld_cpl;
    logic                        w_set_ov;
    logic                        w_set_un;

    logic [P_SLOT_TAG_WIDTH-1:0] w_fifo_tag;
    logic                        w_fifo_dir;
    logic [L_BEAT_W-1:0]         w_fifo_cnt;
    logic                        w_armed;
    logic [P_CNT_WIDTH-1:0]      w_total;
    logic [P_CNT_WIDTH-1:0]      w_done;
    logic [L_SUM_W-1:0]          w_sum;
    logic [L_SUM_W-1:0]          w_total_ext;

    assign w_fifo_tag  = fifo_rd_data[P_FIFO_DATA_WIDTH-1:15];
    assign w_fifo_dir  = fifo_rd_data[14];
    assign w_fifo_cnt  = fifo_rd_data[13:0];
    assign w_armed     = r_rd_word[L_WORD_W-1];
    assign w_total     = r_rd_word[2*P_CNT_WIDTH-1:P_CNT_WIDTH];
    assign w_done      = r_rd_word[P_CNT_WIDTH-1:0];
    // Full-width sum so an overrun is never hidden by wrap-around
    assign w_sum       = L_SUM_W'(w_done) + L_SUM_W'(r_ent_cnt);
    assign w_total_ext = L_SUM_W'(w_total);

    assign set_rdy   = (r_state == S_IDLE);
    assign cpl_valid = (r_state == S_CPL);
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        fifo_rd_en  = 1'b0;
        w_we        = 1'b0;
        w_waddr     = r_init_addr;
        w_wdata     = '0;
        w_rd_addr   = r_ent_tag;
        w_ld_entry  = 1'b0;
        w_ld_cpl    = 1'b0;
        w_set_ov    = 1'b0;
        w_set_un    = 1'b0;
        case (r_state)
            S_INIT: begin
                w_we = 1'b1;
                if (r_init_addr == {P_SLOT_TAG_WIDTH{1'b1}}) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                w_rd_addr = w_fifo_tag;
                if (set_en) begin
                    w_we    = 1'b1;
                    w_waddr = set_tag;
                    w_wdata = {1'b1, set_total, {P_CNT_WIDTH{1'b0}}};
                end else if (fifo_empty_n) begin
                    fifo_rd_en  = 1'b1;
                    w_ld_entry  = 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                w_state_nxt = S_IDLE;
                if (!w_armed) begin
                    w_set_un = 1'b1;
                end else if (w_sum < w_total_ext) begin
                    w_we    = 1'b1;
                    w_waddr = r_ent_tag;
                    w_wdata = {1'b1, w_total, w_sum[P_CNT_WIDTH-1:0]};
                end else begin
                    w_we        = 1'b1;
                    w_waddr     = r_ent_tag;
                    w_ld_cpl    = 1'b1;
                    w_set_ov    = (w_sum > w_total_ext);
                    w_state_nxt = S_CPL;
                end
            end
            S_CPL: begin
                if (cpl_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init_addr <= '0;
            r_ent_tag   <= '0;
            r_ent_dir   <= 1'b0;
            r_ent_cnt   <= '0;
            cpl_tag     <= '0;
            cpl_dir     <= 1'b0;
            err_overrun <= 1'b0;
            err_unarmed <= 1'b0;
        end else begin
            if (r_state == S_INIT) begin
                r_init_addr <= r_init_addr + P_SLOT_TAG_WIDTH'(1);
            end
            if (w_ld_entry) begin
                r_ent_tag <= w_fifo_tag;
                r_ent_dir <= w_fifo_dir;
                r_ent_cnt <= w_fifo_cnt;
            end
            if (w_ld_cpl) begin
                cpl_tag <= r_ent_tag;
                cpl_dir <= r_ent_dir;
            end
            if (w_set_ov) begin
                err_overrun <= 1'b1;
            end
            if (w_set_un) begin
                err_unarmed <= 1'b1;
            end
        end
    end

    // Slot table: one write port, one registered read port
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_rd_word <= r_mem[w_rd_addr];
    end

`ifdef DMA_DONE_TRACKER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pop_cnt <= '0;
            stat_cpl_cnt <= '0;
        end else begin
            if (fifo_rd_en && (stat_pop_cnt != 32'hFFFF_FFFF)) begin
                stat_pop_cnt <= stat_pop_cnt + 32'd1;
            end
            if (cpl_valid && cpl_ready && (stat_cpl_cnt != 32'hFFFF_FFFF)) begin
                stat_cpl_cnt <= stat_cpl_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dma_done_tracker.sv
// Scoreboard bench for dma_done_tracker: a slot-table reference model predicts completions and error flags.
module tb_dma_done_tracker;

    localparam int unsigned TW    = 4;
    localparam int unsigned FW    = TW + 15;
    localparam int unsigned CW    = 16;
    localparam int unsigned NSLOT = 1 << TW;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_rd_en;
    logic [FW-1:0] fifo_rd_data;
    logic          fifo_empty_n;
    logic          set_en;
    logic [TW-1:0] set_tag;
    logic [CW-1:0] set_total;
    logic          set_rdy;
    logic          cpl_valid;
    logic [TW-1:0] cpl_tag;
    logic          cpl_dir;
    logic          cpl_ready;
    logic          err_overrun;
    logic          err_unarmed;
    logic          busy;
`ifdef DMA_DONE_TRACKER_STATS_EN
    logic [31:0]   stat_pop_cnt;
    logic [31:0]   stat_cpl_cnt;
`endif

    dma_done_tracker #(
        .P_SLOT_TAG_WIDTH (TW),
        .P_FIFO_DATA_WIDTH(FW),
        .P_CNT_WIDTH      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .fifo_empty_n(fifo_empty_n),
        .set_en      (set_en),
        .set_tag     (set_tag),
        .set_total   (set_total),
        .set_rdy     (set_rdy),
        .cpl_valid   (cpl_valid),
        .cpl_tag     (cpl_tag),
        .cpl_dir     (cpl_dir),
        .cpl_ready   (cpl_ready),
        .err_overrun (err_overrun),
        .err_unarmed (err_unarmed),
        .busy        (busy)
`ifdef DMA_DONE_TRACKER_STATS_EN
        ,
        .stat_pop_cnt(stat_pop_cnt),
        .stat_cpl_cnt(stat_cpl_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int ready_mode = 0;
    logic pop_s = 1'b0;

    // Reference model: slot table plus expected completion stream
    bit            m_armed [NSLOT];
    int unsigned   m_total [NSLOT];
    int unsigned   m_done  [NSLOT];
    bit            m_err_ov;
    bit            m_err_un;
    int unsigned   m_pops;
    int unsigned   m_cpls;
    logic [FW-1:0] fifo_q[$];
    logic [TW:0]   exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fifo_refresh();
        fifo_empty_n = (fifo_q.size() != 0);
        fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(NSLOT); i++) begin
            m_armed[i] = 1'b0;
            m_total[i] = 0;
            m_done[i]  = 0;
        end
        m_err_ov = 1'b0;
        m_err_un = 1'b0;
        m_pops   = 0;
        m_cpls   = 0;
        exp_q.delete();
        fifo_q.delete();
        fifo_refresh();
    endtask

    task automatic model_arm(input logic [TW-1:0] tag, input int unsigned total);
        m_armed[tag] = 1'b1;
        m_total[tag] = total;
        m_done[tag]  = 0;
    endtask

    // Queue an entry and predict its effect in FIFO order
    task automatic push_entry(input logic [TW-1:0] tag, input logic dir, input logic [13:0] cnt);
        int unsigned sum;
        fifo_q.push_back({tag, dir, cnt});
        fifo_refresh();
        m_pops++;
        if (!m_armed[tag]) begin
            m_err_un = 1'b1;
        end else begin
            sum = m_done[tag] + 32'(cnt);
            if (sum >= m_total[tag]) begin
                if (sum > m_total[tag]) m_err_ov = 1'b1;
                exp_q.push_back({tag, dir});
                m_cpls++;
                m_armed[tag] = 1'b0;
                m_done[tag]  = 0;
            end else begin
                m_done[tag] = sum;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic arm(input logic [TW-1:0] tag, input int unsigned total);
        step();
        set_en    = 1'b1;
        set_tag   = tag;
        set_total = CW'(total);
        model_arm(tag, total);
        step();
        set_en = 1'b0;
    endtask

    task automatic wait_quiet();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (fifo_q.size() == 0 && !busy) break;
        end
        check("quiet_busy", 32'(busy), 32'(0));
        check("cpl_drain", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic check_errs();
        check("err_overrun", 32'(err_overrun), 32'(m_err_ov));
        check("err_unarmed", 32'(err_unarmed), 32'(m_err_un));
    endtask

    task automatic wait_init(input bit entry_waiting);
        int  n;
        bit  viol;
        n    = 0;
        viol = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (set_rdy || fifo_rd_en) viol = 1'b1;
        end
        check("init_cycles", 32'(n), 32'(16));
        check("init_quiet", 32'(viol), 32'(0));
        check("idle_set_rdy", 32'(set_rdy), 32'(1));
        check("idle_first_pop", 32'(fifo_rd_en), 32'(entry_waiting));
    endtask

    // FIFO model: pop on the edge where the DUT strobed rd_en
    always @(negedge clk) pop_s = fifo_rd_en;

    always @(posedge clk) begin
        #1;
        if (pop_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_refresh();
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       cpl_ready = 1'b0;
            2:       cpl_ready = 1'b1;
            default: cpl_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: every accepted completion must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && cpl_valid && cpl_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL cpl_unexpected: got tag %0d dir %0d, expected no completion", cpl_tag, cpl_dir);
            end else begin
                logic [TW:0] e;
                e = exp_q.pop_front();
                check("cpl_tag", 32'(cpl_tag), 32'(e[TW:1]));
                check("cpl_dir", 32'(cpl_dir), 32'(e[0]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TW-1:0] last_tag;
        logic [TW-1:0] rt;
        int            k;
        rst       = 1'b1;
        set_en    = 1'b0;
        set_tag   = '0;
        set_total = '0;
        cpl_ready = 1'b0;
        model_clear();

        // Entry queued while the table is still being cleared
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 32'(busy), 32'(1));
        check("rst_set_rdy", 32'(set_rdy), 32'(0));
        check("rst_cpl_valid", 32'(cpl_valid), 32'(0));
        check("rst_errs", 32'({err_overrun, err_unarmed}), 32'(0));
        push_entry(TW'(2), 1'b1, 14'd5);
        step();
        rst = 1'b0;
        wait_init(1'b1);
        wait_quiet();
        check_errs();

        // Directed completions, overrun and unarmed
        rst = 1'b1;
        model_clear();
        repeat (2) step();
        rst = 1'b0;
        wait_init(1'b0);
        arm(TW'(3), 10);
        step();
        push_entry(TW'(3), 1'b0, 14'd4);
        push_entry(TW'(3), 1'b0, 14'd6);
        wait_quiet();
        check_errs();
        arm(TW'(5), 8);
        step();
        push_entry(TW'(5), 1'b1, 14'd12);
        wait_quiet();
        check_errs();
        step();
        push_entry(TW'(5), 1'b1, 14'd1);
        wait_quiet();
        check_errs();

        // Completion back-pressure, next entry pops right after acceptance
        arm(TW'(7), 1);
        arm(TW'(8), 5);
        ready_mode = 1;
        step();
        push_entry(TW'(7), 1'b0, 14'd1);
        push_entry(TW'(8), 1'b0, 14'd2);
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (cpl_valid) break;
        end
        check("bp_cpl_seen", 32'(cpl_valid), 32'(1));
        k = 0;
        repeat (20) begin
            @(negedge clk);
            if (!cpl_valid || fifo_rd_en) k++;
        end
        check("bp_hold", 32'(k), 32'(0));
        ready_mode = 2;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (cpl_valid && cpl_ready) break;
        end
        check("bp_accept", 32'(cpl_ready && cpl_valid), 32'(1));
        @(negedge clk);
        check("bp_pop_after", 32'(fifo_rd_en), 32'(1));
        ready_mode = 0;
        wait_quiet();
        check_errs();

        // Set and pop requested together: set first, pop next cycle
        step();
        set_en    = 1'b1;
        set_tag   = TW'(9);
        set_total = CW'(3);
        model_arm(TW'(9), 3);
        push_entry(TW'(9), 1'b1, 14'd3);
        @(negedge clk);
        check("same_cyc_no_pop", 32'(fifo_rd_en), 32'(0));
        check("same_cyc_set_rdy", 32'(set_rdy), 32'(1));
        step();
        set_en = 1'b0;
        @(negedge clk);
        check("same_cyc_pop_next", 32'(fifo_rd_en), 32'(1));
        wait_quiet();
        check_errs();

        // Randomized traffic against the model
        last_tag = '0;
        repeat (40) begin
            if ($urandom_range(0, 2) != 0) begin
                last_tag = TW'($urandom_range(0, NSLOT - 1));
                arm(last_tag, $urandom_range(1, 15));
            end
            step();
            repeat ($urandom_range(1, 4)) begin
                rt = ($urandom_range(0, 3) != 0) ? last_tag : TW'($urandom_range(0, NSLOT - 1));
                push_entry(rt, 1'($urandom_range(0, 1)), 14'($urandom_range(0, 9)));
                if ($urandom_range(0, 1) != 0) step();
            end
            wait_quiet();
            check_errs();
        end

`ifdef DMA_DONE_TRACKER_STATS_EN
        check("stat_pop_cnt", stat_pop_cnt, 32'(m_pops));
        check("stat_cpl_cnt", stat_cpl_cnt, 32'(m_cpls));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_done_tracker.md
Name: dma_done_tracker

Overview:
- Sits directly downstream of the DMA-done FIFO and is its only reader. Each entry is {slot tag, direction, beat count}.
- Accumulates completed DMA beats per slot tag against a programmed expected total.
- When a slot's total is reached, emits one completion (tag, direction) to the command-completion logic and disarms the slot.

Parameters:
- P_SLOT_TAG_WIDTH, 10, slot tag width; tracker depth = 2^P_SLOT_TAG_WIDTH slots.
- P_FIFO_DATA_WIDTH, P_SLOT_TAG_WIDTH+15, FIFO entry width. Fields: [W-1:15] tag, [14] dir, [13:0] beat count.
- P_CNT_WIDTH, 16, width of per-slot total and accumulated counters.

Ports:
- clk  in  1  single clock, shared with the FIFO read side.
- rst  in  1  asynchronous, active-high reset.
- fifo_rd_en  out  1  one-cycle pop strobe to the FIFO.
- fifo_rd_data  in  P_FIFO_DATA_WIDTH  FIFO head entry; valid whenever fifo_empty_n=1.
- fifo_empty_n  in  1  FIFO not empty.
- set_en  in  1  arm a slot; accepted only while set_rdy=1.
- set_tag  in  P_SLOT_TAG_WIDTH  slot to arm.
- set_total  in  P_CNT_WIDTH  expected beats for the slot; 0 is illegal.
- set_rdy  out  1  block can accept set_en this cycle.
- cpl_valid  out  1  completion available.
- cpl_tag  out  P_SLOT_TAG_WIDTH  completed slot.
- cpl_dir  out  1  direction bit of the last entry for that slot.
- cpl_ready  in  1  downstream accepts the completion.
- err_overrun  out  1  sticky: accumulated count exceeded total.
- err_unarmed  out  1  sticky: FIFO entry arrived for a disarmed slot.
- busy  out  1  high in any state other than S_IDLE.

Behaviour:
- Reset is asynchronous and active-high on rst; clk is the only clock.
- Per-slot storage: inferred synchronous-read RAM, word = {armed, total[P_CNT_WIDTH-1:0], done[P_CNT_WIDTH-1:0]}, read latency 1.
- Reset values: state=S_INIT, fifo_rd_en=0, set_rdy=0, cpl_valid=0, cpl_tag=0, cpl_dir=0, err_*=0, busy=1.
- S_INIT:
  - Writes all-zero words to addresses 0..2^P_SLOT_TAG_WIDTH-1, one per cycle.
  - No pops, no sets.
  - After the last address -> S_IDLE. Duration is exactly 2^P_SLOT_TAG_WIDTH cycles.
- S_IDLE, set_rdy=1:
  - If set_en: write {1, set_total, 0} to set_tag in the same cycle; stay in S_IDLE. Set has priority over pop.
  - Else if fifo_empty_n: fifo_rd_en=1 for that cycle (combinational). Latch fifo_rd_data into r_entry, drive RAM read address = tag, go to S_READ.
- S_READ: wait one cycle for RAM data, then -> S_UPDATE.
- S_UPDATE: sum = done + cnt, computed at P_CNT_WIDTH+1 bits with no truncation.
  - armed=0: set err_unarmed, leave RAM unchanged, -> S_IDLE.
  - sum < total: write done=sum, -> S_IDLE.
  - sum >= total: write {0,0,0}, load cpl_tag=tag and cpl_dir=dir, -> S_CPL. If sum > total, also set err_overrun.
- S_CPL: cpl_valid=1, cpl_tag and cpl_dir held stable. On cpl_ready=1, cpl_valid drops the next cycle, -> S_IDLE.
- Throughput: minimum 3 cycles per entry (IDLE, READ, UPDATE), plus one or more cycles in S_CPL when completing. The FIFO's empty_n always settles before the next pop, so there is no stale-empty hazard.
- Sets only land in S_IDLE, so a set can never race with an update to the same tag.
- Beat count 0 in an entry is legal: it is accumulated with no change, and completes only if total is already met (impossible with total>=1).
- Re-arming an armed slot overwrites total and clears done.
- err_* clear only on rst.
- Reset mid-operation aborts any in-flight entry; the popped entry is lost. RAM is re-zeroed via S_INIT.

Optional Feature:
- Macro DMA_DONE_TRACKER_STATS_EN.
- Defined: adds outputs stat_pop_cnt[31:0] and stat_cpl_cnt[31:0].
  - stat_pop_cnt increments on each fifo_rd_en; stat_cpl_cnt increments on each cpl_valid&cpl_ready.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with P_SLOT_TAG_WIDTH=4 -> busy=1 and set_rdy=0 for exactly 16 cycles, then busy=0 and set_rdy=1; an entry queued during init is not popped until S_IDLE.
- Set tag 3 total 10; push {3,0,4} then {3,0,6} -> one cpl_valid with cpl_tag=3, cpl_dir=0 after the second entry; no errors.
- Set tag 5 total 8; push {5,1,12} -> completion tag 5, dir 1; err_overrun=1; slot 5 disarmed (a subsequent {5,1,1} sets err_unarmed).
- Completion for tag 7 with cpl_ready held 0 for 20 cycles -> cpl_valid held, no fifo_rd_en while waiting; after ready, the next entry pops 1 cycle later.
- set_en and fifo_empty_n asserted in the same cycle -> set written, no pop that cycle; pop occurs the next cycle.
- With DMA_DONE_TRACKER_STATS_EN: 5 entries giving 2 completions -> stat_pop_cnt=5, stat_cpl_cnt=2.
